// File: rtl/redmule_pkg.sv
// redmule_pkg: shared context states and config-map offsets for the RedMulE job register file
package redmule_pkg;
  typedef enum logic [1:0] {CTX_FREE, CTX_PROG, CTX_PENDING, CTX_RUNNING} ctx_state_e;
  localparam int unsigned ACQUIRE_OFFS    = 32;
  localparam int unsigned TRIGGER_OFFS    = 33;
  localparam int unsigned STATUS_OFFS     = 34;
  localparam int unsigned SOFT_CLEAR_OFFS = 35;
  localparam logic [31:0] ACQUIRE_FAIL    = 32'hFFFF_FFFF;
endpackage

// File: rtl/redmule_ctx_queue.sv
// redmule_ctx_queue: in-order FIFO of context ids, shift-down on pop, with synchronous clear
module redmule_ctx_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [W-1:0]     id_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop_i && cnt_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (push_i && cnt_d != CNT_W'(DEPTH)) begin
      for (int i = 0; i < DEPTH; i++) if (CNT_W'(i) == cnt_d) mem_d[i] = id_i;
      cnt_d = cnt_d + CNT_W'(1);
    end
    if (clear_i) cnt_d = '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end
  assign head_o  = mem_q[0];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/redmule_ctx_regfile.sv
// redmule_ctx_regfile: multi-context job register file feeding the RedMulE scheduler
// through an in-order job queue, with acquire/trigger/status/soft-clear config commands.
module redmule_ctx_regfile
  import redmule_pkg::*;
#(
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned N_REGS    = 19,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CFG_AW    = 6,
  localparam int unsigned ID_W     = N_CONTEXT > 1 ? $clog2(N_CONTEXT) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_req_i,
  output logic                     cfg_gnt_o,
  input  logic                     cfg_we_i,
  input  logic [CFG_AW-1:0]        cfg_addr_i,
  input  logic [DATA_W-1:0]        cfg_wdata_i,
  output logic [DATA_W-1:0]        cfg_rdata_o,
  output logic                     cfg_rvalid_o,
  output logic                     job_valid_o,
  input  logic                     job_ready_i,
  output logic [ID_W-1:0]          job_ctx_o,
  output logic [N_REGS*DATA_W-1:0] job_regs_o,
  input  logic                     job_done_i,
  output logic                     clear_o,
  output logic [N_CONTEXT-1:0]     evt_o
);
  localparam int unsigned CNT_W = $clog2(N_CONTEXT + 1);
  ctx_state_e          state_q [N_CONTEXT];
  ctx_state_e          state_d [N_CONTEXT];
  logic [DATA_W-1:0]   regs_q [N_CONTEXT][N_REGS];
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, clear_q;
  logic [N_CONTEXT-1:0] evt_q, evt_d, free_mask;
  logic                has_prog, has_run, has_free;
  logic [ID_W-1:0]     prog_id, run_id, free_id, head_id;
  logic [CNT_W-1:0]    q_cnt;
  logic                q_empty, rd, wr, acq_take, trig, sclr, hs, done;
  logic [31:0]         status;
  // Context roles are derived from the per-context states; at most one PROG and one RUNNING exist.
  always_comb begin
    has_prog  = 1'b0;
    has_run   = 1'b0;
    has_free  = 1'b0;
    prog_id   = '0;
    run_id    = '0;
    free_id   = '0;
    free_mask = '0;
    for (int c = N_CONTEXT - 1; c >= 0; c--) begin
      free_mask[c] = (state_q[c] == CTX_FREE);
      if (state_q[c] == CTX_PROG) begin
        has_prog = 1'b1;
        prog_id  = ID_W'(c);
      end
      if (state_q[c] == CTX_RUNNING) begin
        has_run = 1'b1;
        run_id  = ID_W'(c);
      end
      if (state_q[c] == CTX_FREE) begin
        has_free = 1'b1;
        free_id  = ID_W'(c);
      end
    end
  end
  assign rd          = cfg_req_i & ~cfg_we_i;
  assign wr          = cfg_req_i & cfg_we_i;
  assign acq_take    = rd && cfg_addr_i == CFG_AW'(ACQUIRE_OFFS) && !has_prog && has_free;
  assign trig        = wr && cfg_addr_i == CFG_AW'(TRIGGER_OFFS) && has_prog;
  assign sclr        = wr && cfg_addr_i == CFG_AW'(SOFT_CLEAR_OFFS);
  assign job_valid_o = !q_empty && !has_run;
  assign hs          = job_valid_o & job_ready_i;
  assign done        = job_done_i & has_run;
  assign job_ctx_o   = has_run ? run_id : head_id;
  assign cfg_gnt_o   = 1'b1;
  redmule_ctx_queue #(.DEPTH(N_CONTEXT), .W(ID_W)) i_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (sclr),
    .push_i  (trig),
    .id_i    (prog_id),
    .pop_i   (hs),
    .head_o  (head_id),
    .count_o (q_cnt),
    .empty_o (q_empty)
  );
  // The four transitions always target different contexts, so they can be applied in sequence.
  always_comb begin
    state_d = state_q;
    for (int c = 0; c < N_CONTEXT; c++) begin
      if (acq_take && free_id == ID_W'(c)) state_d[c] = CTX_PROG;
      if (trig && prog_id == ID_W'(c)) state_d[c] = CTX_PENDING;
      if (hs && head_id == ID_W'(c)) state_d[c] = CTX_RUNNING;
      if (done && run_id == ID_W'(c)) state_d[c] = CTX_FREE;
      if (sclr) state_d[c] = CTX_FREE;
      evt_d[c] = done && !sclr && run_id == ID_W'(c);
    end
  end
  assign status = {16'(free_mask), 3'b0, 5'(q_cnt), 7'b0, has_run};
  always_comb begin
    rdata_d = '0;
    for (int r = 0; r < N_REGS; r++)
      if (has_prog && cfg_addr_i == CFG_AW'(r)) rdata_d = regs_q[prog_id][r];
    if (cfg_addr_i == CFG_AW'(ACQUIRE_OFFS))
      rdata_d = has_prog ? DATA_W'(prog_id) : has_free ? DATA_W'(free_id) : DATA_W'(ACQUIRE_FAIL);
    if (cfg_addr_i == CFG_AW'(STATUS_OFFS)) rdata_d = DATA_W'(status);
  end
  always_comb begin
    job_regs_o = '0;
    for (int r = 0; r < N_REGS; r++) job_regs_o[r*DATA_W +: DATA_W] = regs_q[job_ctx_o][r];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < N_CONTEXT; c++) state_q[c] <= CTX_FREE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      clear_q  <= 1'b0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rd ? rdata_d : rdata_q;
      rvalid_q <= rd;
      clear_q  <= sclr;
      evt_q    <= evt_d;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < N_CONTEXT; c++)
        for (int r = 0; r < N_REGS; r++) regs_q[c][r] <= '0;
    end else begin
      for (int c = 0; c < N_CONTEXT; c++)
        for (int r = 0; r < N_REGS; r++)
          if (wr && has_prog && prog_id == ID_W'(c) && cfg_addr_i == CFG_AW'(r))
            regs_q[c][r] <= cfg_wdata_i;
    end
  end
  assign cfg_rdata_o  = rdata_q;
  assign cfg_rvalid_o = rvalid_q;
  assign clear_o      = clear_q;
  assign evt_o        = evt_q;
endmodule

// File: tb/tb_redmule_ctx_regfile.sv
// tb_redmule_ctx_regfile: directed scenario tests for the two-context, 19-register job register file
module tb_redmule_ctx_regfile;
  localparam logic [5:0] A_ACQ = 6'd32, A_TRIG = 6'd33, A_STAT = 6'd34, A_SCLR = 6'd35;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req = 1'b0, cfg_we = 1'b0, cfg_gnt, cfg_rvalid;
  logic [5:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0, cfg_rdata;
  logic        job_valid, job_ready = 1'b0, job_done = 1'b0, clear;
  logic [0:0]  job_ctx;
  logic [19*32-1:0] job_regs;
  logic [1:0]  evt;
  int          checks = 0, failures = 0;
  logic [31:0] d;
  logic        v;

  redmule_ctx_regfile dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_req_i(cfg_req), .cfg_gnt_o(cfg_gnt), .cfg_we_i(cfg_we),
    .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .cfg_rvalid_o(cfg_rvalid),
    .job_valid_o(job_valid), .job_ready_i(job_ready), .job_ctx_o(job_ctx), .job_regs_o(job_regs),
    .job_done_i(job_done), .clear_o(clear), .evt_o(evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_read(input logic [5:0] a, output logic [31:0] data, output logic valid);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    tick();
    cfg_req = 1'b0;
    data = cfg_rdata;
    valid = cfg_rvalid;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [31:0] data);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = data;
    tick();
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic pulse_ready();
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (job_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", job_valid); end
    checks++; if (cfg_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", cfg_rvalid); end
    checks++; if (cfg_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cfg_rdata); end
    checks++; if ({clear, evt} !== 3'b000) begin failures++; $display("FAIL reset_clear_evt got=%b exp=000", {clear, evt}); end
    checks++; if (cfg_gnt !== 1'b1) begin failures++; $display("FAIL reset_gnt got=%b exp=1", cfg_gnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_acquire();
    cfg_read(A_ACQ, d, v);
    checks++; if ({v, d} !== {1'b1, 32'h0}) begin failures++; $display("FAIL acq_first got=%b/%h exp=1/0", v, d); end
    tick();
    checks++; if (cfg_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_one_cycle got=%b exp=0", cfg_rvalid); end
    cfg_read(A_ACQ, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL acq_again got=%h exp=0", d); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0002_0000) begin failures++; $display("FAIL status_prog got=%h exp=00020000", d); end
  endtask

  task automatic test_dispatch();
    cfg_write(6'd0, 32'h1000);
    cfg_write(A_TRIG, 32'h0);
    checks++; if ({job_valid, job_ctx} !== 2'b10) begin failures++; $display("FAIL disp_valid got=%b%b exp=10", job_valid, job_ctx); end
    checks++; if (job_regs[31:0] !== 32'h1000) begin failures++; $display("FAIL disp_reg0 got=%h exp=1000", job_regs[31:0]); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0002_0100) begin failures++; $display("FAIL status_pend got=%h exp=00020100", d); end
    pulse_ready();
    checks++; if (job_valid !== 1'b0) begin failures++; $display("FAIL disp_drop got=%b exp=0", job_valid); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0002_0001) begin failures++; $display("FAIL status_run got=%h exp=00020001", d); end
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    checks++; if (evt !== 2'b01) begin failures++; $display("FAIL done_evt got=%b exp=01", evt); end
    tick();
    checks++; if (evt !== 2'b00) begin failures++; $display("FAIL done_evt_pulse got=%b exp=00", evt); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0003_0000) begin failures++; $display("FAIL status_free got=%h exp=00030000", d); end
  endtask

  task automatic test_fill();
    cfg_read(A_ACQ, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL fill_acq0 got=%h exp=0", d); end
    cfg_write(6'd0, 32'h1000);
    cfg_write(A_TRIG, 32'h0);
    cfg_read(A_ACQ, d, v);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL fill_acq1 got=%h exp=1", d); end
    cfg_write(6'd0, 32'h2000);
    cfg_write(A_TRIG, 32'h0);
    cfg_read(A_ACQ, d, v);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL fill_acq_full got=%h exp=ffffffff", d); end
    checks++; if ({job_valid, job_ctx, job_regs[31:0]} !== {2'b10, 32'h1000}) begin
      failures++; $display("FAIL fill_head got=%b%b/%h exp=10/1000", job_valid, job_ctx, job_regs[31:0]); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0000_0200) begin failures++; $display("FAIL status_full got=%h exp=00000200", d); end
    pulse_ready();
    repeat (3) tick();
    checks++; if ({job_valid, job_ctx, job_regs[31:0]} !== {2'b00, 32'h1000}) begin
      failures++; $display("FAIL run_stable got=%b%b/%h exp=00/1000", job_valid, job_ctx, job_regs[31:0]); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0000_0101) begin failures++; $display("FAIL status_run_pend got=%h exp=00000101", d); end
  endtask

  task automatic test_done_acquire();
    job_done = 1'b1;
    cfg_read(A_ACQ, d, v);
    job_done = 1'b0;
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL same_cycle_acq got=%h exp=ffffffff", d); end
    checks++; if (evt !== 2'b01) begin failures++; $display("FAIL same_cycle_evt got=%b exp=01", evt); end
    checks++; if ({job_valid, job_ctx, job_regs[31:0]} !== {2'b11, 32'h2000}) begin
      failures++; $display("FAIL second_head got=%b%b/%h exp=11/2000", job_valid, job_ctx, job_regs[31:0]); end
    cfg_read(A_ACQ, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL acq_freed got=%h exp=0", d); end
    pulse_ready();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    checks++; if (evt !== 2'b10) begin failures++; $display("FAIL done_ctx1_evt got=%b exp=10", evt); end
  endtask

  task automatic test_soft_clear();
    cfg_write(A_TRIG, 32'h0);
    pulse_ready();
    cfg_read(A_ACQ, d, v);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL sclr_setup_acq got=%h exp=1", d); end
    cfg_write(A_TRIG, 32'h0);
    job_done = 1'b1;
    cfg_write(A_SCLR, 32'h0);
    job_done = 1'b0;
    checks++; if ({clear, job_valid, evt} !== 4'b1000) begin
      failures++; $display("FAIL sclr_pulse got=%b exp=1000", {clear, job_valid, evt}); end
    tick();
    checks++; if ({clear, job_valid, evt} !== 4'b0000) begin
      failures++; $display("FAIL sclr_after got=%b exp=0000", {clear, job_valid, evt}); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0003_0000) begin failures++; $display("FAIL sclr_status got=%h exp=00030000", d); end
    cfg_read(A_ACQ, d, v);
    cfg_read(6'd0, d, v);
    checks++; if (d !== 32'h1000) begin failures++; $display("FAIL sclr_bank_kept got=%h exp=1000", d); end
    cfg_write(A_SCLR, 32'h0);
  endtask

  task automatic test_idle();
    cfg_write(A_TRIG, 32'h0);
    cfg_write(6'd0, 32'hDEAD);
    cfg_read(6'd0, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL idle_reg_read got=%h exp=0", d); end
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    checks++; if ({job_valid, evt} !== 3'b000) begin failures++; $display("FAIL idle_done got=%b exp=000", {job_valid, evt}); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0003_0000) begin failures++; $display("FAIL idle_status got=%h exp=00030000", d); end
    cfg_read(A_ACQ, d, v);
    cfg_read(6'd0, d, v);
    checks++; if (d !== 32'h1000) begin failures++; $display("FAIL idle_write_dropped got=%h exp=1000", d); end
    cfg_write(6'd20, 32'h5555);
    cfg_read(6'd20, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL hole_read got=%h exp=0", d); end
    cfg_write(6'd18, 32'h1818);
    cfg_read(6'd18, d, v);
    checks++; if (d !== 32'h1818) begin failures++; $display("FAIL last_reg got=%h exp=1818", d); end
  endtask

  task automatic test_async_reset();
    cfg_write(A_TRIG, 32'h0);
    pulse_ready();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({job_valid, evt, clear} !== 4'b0000) begin
      failures++; $display("FAIL async_rst got=%b exp=0000", {job_valid, evt, clear}); end
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (evt !== 2'b00) begin failures++; $display("FAIL async_rst_evt got=%b exp=00", evt); end
    cfg_read(A_STAT, d, v);
    checks++; if (d !== 32'h0003_0000) begin failures++; $display("FAIL async_rst_status got=%h exp=00030000", d); end
    cfg_read(A_ACQ, d, v);
    cfg_read(6'd18, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL async_rst_bank got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_dispatch();
    test_fill();
    test_done_acquire();
    test_soft_clear();
    test_idle();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
